vga_sync_monitor: RTL and testbench

- Receive-side counterpart to the VGA timing generator: watches hsync/vsync and recovers pixel coordinates, visible-area flag and frame boundaries.
- Checks line and frame lengths against the 640x480@60 timing and reports lock and errors.
- Sits in MonitorVGA alongside the generator; used as in-system checker and bench scoreboard front-end.

---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/sync_edge_det.sv | 17 +
 rtl/vga_sync_monitor.sv | 134 +++++++++++++
 tb/tb_vga_sync_monitor.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants and the sync-monitor state encoding.
// Shared by the VGA timing generator and vga_sync_monitor.
package vga_timing_pkg;
  localparam int VGA_H_VISIBLE  = 640;
  localparam int VGA_H_FRONT    = 16;
  localparam int VGA_H_SYNC     = 96;
  localparam int VGA_H_BACK     = 48;
  localparam int VGA_V_VISIBLE  = 480;
  localparam int VGA_V_FRONT    = 10;
  localparam int VGA_V_SYNC     = 2;
  localparam int VGA_V_BACK     = 33;
  localparam int VGA_LOCK_LINES = 4;
  localparam int VGA_H_TOTAL    = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL    = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } sync_state_e;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       active;
  } pix_pos_t;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3ff) ? v : v + 10'd1;
  endfunction
endpackage

// File: rtl/sync_edge_det.sv
// Sync history register plus active-low assertion (falling-edge) strobe, gated by en.
module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic din,
  output logic fall
);
  logic q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  q <= 1'b1;
    else if (en) q <= din;
  end

  assign fall = en & q & ~din;
endmodule

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA sync checker: recovers x/y/active from hsync/vsync and tracks lock.
// Define VGA_SYNC_MON_STATS_EN to add the err_count and lines_seen outputs.
module vga_sync_monitor
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = VGA_H_VISIBLE,
  parameter int H_FRONT    = VGA_H_FRONT,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BACK     = VGA_H_BACK,
  parameter int V_VISIBLE  = VGA_V_VISIBLE,
  parameter int V_FRONT    = VGA_V_FRONT,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BACK     = VGA_V_BACK,
  parameter int LOCK_LINES = VGA_LOCK_LINES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       locked,
  output logic       frame_start,
  output logic       timing_err
`ifdef VGA_SYNC_MON_STATS_EN
  ,
  output logic [7:0] err_count,
  output logic [9:0] lines_seen
`endif
);
  localparam int GLW = $clog2(LOCK_LINES + 1);
  localparam logic [9:0] H_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_FIRST = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_END   = 10'(H_SYNC + H_BACK + H_VISIBLE - 1);
  localparam logic [9:0] V_FIRST = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_END   = 10'(V_SYNC + V_BACK + V_VISIBLE - 1);
  localparam logic [GLW-1:0] GL_MAX = GLW'(LOCK_LINES);

  sync_state_e    state;
  logic [9:0]     hcnt, vcnt, hcnt_n, vcnt_n;
  logic [GLW-1:0] good_lines, gl_inc;
  logic           hs_edge, vs_edge, line_ok, frame_ok, lock_err, hv, vv;
  pix_pos_t       pos;

  sync_edge_det u_hs (.clk, .reset, .en(enable),  .din(hsync), .fall(hs_edge));
  // vsync only matters at line boundaries, so its history advances on hs_edge
  sync_edge_det u_vs (.clk, .reset, .en(hs_edge), .din(vsync), .fall(vs_edge));

  assign line_ok  = (hcnt == H_LAST);
  assign frame_ok = (vcnt == V_LAST);
  assign lock_err = hs_edge && (state == LOCKED) && (!line_ok || (vs_edge && !frame_ok));
  assign gl_inc   = (good_lines >= GL_MAX) ? GL_MAX : good_lines + 1'b1;
  assign hcnt_n   = hs_edge ? '0 : sat_inc10(hcnt);
  assign vcnt_n   = vs_edge ? '0 : (hs_edge ? sat_inc10(vcnt) : vcnt);
  assign hv       = (hcnt_n >= H_FIRST) && (hcnt_n <= H_END);
  assign vv       = (vcnt_n >= V_FIRST) && (vcnt_n <= V_END);

  // State only moves on hs_edge; the locking vs_edge also raises frame_start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= SEARCH;
      good_lines  <= '0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      timing_err  <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      timing_err  <= 1'b0;
      if (hs_edge) begin
        unique case (state)
          SEARCH: begin
            state      <= MEASURE;
            good_lines <= '0;
          end
          MEASURE: begin
            good_lines <= line_ok ? gl_inc : '0;
            if (vs_edge && line_ok && (gl_inc >= GL_MAX)) begin
              state       <= LOCKED;
              locked      <= 1'b1;
              frame_start <= 1'b1;
            end
          end
          LOCKED: begin
            if (lock_err) begin
              state      <= SEARCH;
              locked     <= 1'b0;
              timing_err <= 1'b1;
            end else if (vs_edge) begin
              frame_start <= 1'b1;
            end
          end
          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcnt <= '0;
      vcnt <= '0;
      pos  <= '0;
    end else if (enable) begin
      hcnt       <= hcnt_n;
      vcnt       <= vcnt_n;
      pos.x      <= hv ? hcnt_n - H_FIRST : '0;
      pos.y      <= vv ? vcnt_n - V_FIRST : '0;
      // hv is 0 on every hs_edge, so the pre-edge state is safe to use here
      pos.active <= hv && vv && (state == LOCKED);
    end
  end

  assign x      = pos.x;
  assign y      = pos.y;
  assign active = pos.active;

`ifdef VGA_SYNC_MON_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count  <= '0;
      lines_seen <= '0;
    end else begin
      if (lock_err && (err_count != 8'hff)) err_count <= err_count + 8'd1;
      if (vs_edge) lines_seen <= sat_inc10(vcnt);
    end
  end
`endif
endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor on a scaled-down timing; optional VGA_SYNC_MON_STATS_EN ports.
module tb_vga_sync_monitor;
  localparam int HV = 16, HF = 2, HS = 4, HB = 3;
  localparam int VV = 6,  VF = 1, VS = 2, VB = 2;
  localparam int LL = 4;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, hsync = 1'b1, vsync = 1'b1;
  logic [9:0] x, y;
  logic active, locked, frame_start, timing_err;
`ifdef VGA_SYNC_MON_STATS_EN
  logic [7:0] err_count;
  logic [9:0] lines_seen;
`endif

  always #5 clk = ~clk;

  vga_sync_monitor #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .LOCK_LINES(LL)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .hsync(hsync), .vsync(vsync),
    .x(x), .y(y), .active(active), .locked(locked),
    .frame_start(frame_start), .timing_err(timing_err)
`ifdef VGA_SYNC_MON_STATS_EN
    , .err_count(err_count), .lines_seen(lines_seen)
`endif
  );

  int checks = 0, errors = 0;
  // pixel generator position and pending line/frame lengths
  int gh = 0, gv = 0, cur_len = HT, next_len = HT, frame_len = VT, next_frame = VT;
  // reference model
  int p_hs, p_vs, mh, mv, mode, gl, n_err, last_fl;
  int e_x, e_y, e_act, e_lock, e_fs, e_err;
  int fs_seen = 0, te_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    p_hs = 1; p_vs = 1; mh = 0; mv = 0; mode = 0; gl = 0; n_err = 0; last_fl = 0;
    e_x = 0; e_y = 0; e_act = 0; e_lock = 0; e_fs = 0; e_err = 0;
  endtask

  // mode: 0 searching, 1 measuring, 2 locked
  task automatic model_step(input bit en, input bit hs, input bit vs);
    bit he, ve, lok, fok, hvis, vvis;
    e_err = 0; e_fs = 0;
    if (!en) return;
    he = (p_hs == 1) && !hs; p_hs = hs;
    ve = he && (p_vs == 1) && !vs;
    if (he) p_vs = vs;
    lok = (mh == HT - 1);
    fok = (mv == VT - 1);
    if (he) begin
      if (mode == 0) begin
        mode = 1; gl = 0;
      end else if (mode == 1) begin
        gl = lok ? ((gl < LL) ? gl + 1 : LL) : 0;
        if (ve && gl >= LL) mode = 2;
      end else if (!lok || (ve && !fok)) begin
        e_err = 1; mode = 0; n_err++;
      end
    end
    e_fs = (ve && mode == 2) ? 1 : 0;
    if (ve) last_fl = (mv + 1 > 1023) ? 1023 : mv + 1;
    mh = he ? 0 : ((mh < 1023) ? mh + 1 : 1023);
    mv = ve ? 0 : (he ? ((mv < 1023) ? mv + 1 : 1023) : mv);
    e_lock = (mode == 2) ? 1 : 0;
    hvis = (mh >= HS + HB) && (mh < HS + HB + HV);
    vvis = (mv >= VS + VB) && (mv < VS + VB + VV);
    e_x = hvis ? mh - (HS + HB) : 0;
    e_y = vvis ? mv - (VS + VB) : 0;
    e_act = (hvis && vvis && e_lock == 1) ? 1 : 0;
  endtask

  task automatic tick(input bit en);
    bit hs, vs;
    hs = (gh >= HS);
    vs = (gv >= VS);
    enable = en; hsync = hs; vsync = vs;
    @(posedge clk); #1;
    model_step(en, hs, vs);
    chk("x", x, e_x);
    chk("y", y, e_y);
    chk("active", active, e_act);
    chk("locked", locked, e_lock);
    chk("frame_start", frame_start, e_fs);
    chk("timing_err", timing_err, e_err);
    if (frame_start === 1'b1) fs_seen++;
    if (timing_err === 1'b1) te_seen++;
    if (en) begin
      gh++;
      if (gh == cur_len) begin
        gh = 0; gv++; cur_len = next_len; next_len = HT;
        if (gv == frame_len) begin
          gv = 0; frame_len = next_frame; next_frame = VT;
        end
      end
    end
  endtask

  task automatic run_to(input int h, input int v);
    int n = 0;
    while (!(gh == h && gv == v) && n < 2 * FRAME) begin tick(1); n++; end
    chk("run_to_bound", (n < 2 * FRAME), 1);
    tick(1);
  endtask

  task automatic wait_lock(input string tag);
    int n = 0;
    while (locked !== 1'b1 && n < 3 * FRAME) begin tick(1); n++; end
    chk(tag, locked, 1);
    chk({tag, "_at_gh"}, gh, 1);
    chk({tag, "_at_gv"}, gv, 0);
  endtask

  task automatic wait_err(input string tag);
    int n = 0;
    while (timing_err !== 1'b1 && n < 2 * FRAME) begin tick(1); n++; end
    chk(tag, timing_err, 1);
    chk({tag, "_unlock"}, locked, 0);
    tick(1);
    chk({tag, "_one_clk"}, timing_err, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_x"}, x, 0);
    chk({tag, "_y"}, y, 0);
    chk({tag, "_active"}, active, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_fs"}, frame_start, 0);
    chk({tag, "_err"}, timing_err, 0);
`ifdef VGA_SYNC_MON_STATS_EN
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_lines_seen"}, lines_seen, 0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int te0;
    model_reset();
    #2 reset = 1'b0;
    #1 chk_all_zero("por");
    @(posedge clk); #1 reset = 1'b1;

    // two clean frames: lock on the second vs_edge, no errors
    for (int i = 0; i < 2 * FRAME; i++) tick(1);
    chk("lock_2frames", locked, 1);
    chk("fs_count_2frames", fs_seen, 1);
    chk("no_err_clean", te_seen, 0);

    // visible-area corners
    run_to(HS + HB, VS + VB);
    chk("first_x", x, 0); chk("first_y", y, 0); chk("first_act", active, 1);
    run_to(HS + HB + HV - 1, VS + VB + VV - 1);
    chk("last_x", x, HV - 1); chk("last_y", y, VV - 1); chk("last_act", active, 1);
    tick(1);
    chk("past_x", x, 0); chk("past_act", active, 0);

    // enable stall mid-line
    run_to(HS + HB + 5, VS + VB + 2);
    for (int i = 0; i < 50; i++) tick(0);
    chk("freeze_x", x, 5); chk("freeze_y", y, 2); chk("freeze_act", active, 1);
    te0 = te_seen;
    for (int i = 0; i < FRAME; i++) tick(1);
    chk("freeze_no_err", te_seen, te0);

    // asynchronous reset between clock edges
    run_to(HS + HB + 3, VS + VB + 1);
    #3 reset = 1'b0;
    #1 chk_all_zero("async_rst");
    @(posedge clk); #1 reset = 1'b1;
    model_reset();
    wait_lock("relock_after_reset");

    // one short line, one short frame, one long line
    run_to(0, 2);
    next_len = HT - 1;
    wait_err("short_line");
    wait_lock("relock_short_line");
    next_frame = VT - 1;
    wait_err("short_frame");
    chk("short_frame_gv", gv, 0);
    wait_lock("relock_short_frame");
    run_to(0, 3);
    next_len = HT + 1;
    wait_err("long_line");
`ifdef VGA_SYNC_MON_STATS_EN
    chk("err_count_3", err_count, 3);
`endif
    wait_lock("relock_long_line");

    // randomized enable gaps and occasional line/frame length faults
    for (int i = 0; i < 5 * FRAME; i++) begin
      if (gh == 0 && $urandom_range(0, 39) == 0) next_len = HT - 1 + 2 * int'($urandom_range(0, 1));
      if (gh == 0 && gv == 0 && $urandom_range(0, 3) == 0)
        next_frame = ($urandom_range(0, 1) == 1) ? VT + 1 : VT - 1;
      tick($urandom_range(0, 3) != 0);
    end
`ifdef VGA_SYNC_MON_STATS_EN
    chk("err_count_final", err_count, (n_err > 255) ? 255 : n_err);
    chk("lines_seen_final", lines_seen, last_fl);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
